// File: rtl/tff_seq_pkg.sv
// Shared types and defaults for the T flip-flop pulse sequencer.
package tff_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NT_DEF  = 3;
  localparam int CW_DEF  = 8;
  localparam int GAP_DEF = 1;

  // Gap counter width: enough to hold GAP, never below one bit.
  function automatic int gap_cnt_width(input int gap);
    return (gap < 2) ? 1 : $clog2(gap + 1);
  endfunction

endpackage

// File: rtl/tff_pulse_sequencer_if.sv
// Command/toggle bundle between a requester and the pulse sequencer.
interface tff_pulse_sequencer_if
  import tff_seq_pkg::*;
#(
  parameter int NT = NT_DEF,
  parameter int CW = CW_DEF
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic [NT-1:0] cmd_mask;
  logic [CW-1:0] cmd_count;
  logic          abort;
  logic [NT-1:0] t;
  logic          busy;
  logic          done;
  logic [CW-1:0] pulses_left;

  modport master (
    output cmd_valid, cmd_mask, cmd_count, abort,
    input  cmd_ready, t, busy, done, pulses_left
  );

  modport slave (
    input  cmd_valid, cmd_mask, cmd_count, abort,
    output cmd_ready, t, busy, done, pulses_left
  );

endinterface

// File: rtl/tff_seq_cnt.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module tff_seq_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_value,
  output logic         o_zero
);

  logic [W-1:0] r_value;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_dec && (r_value != '0)) begin
      r_value <= r_value - W'(1);
    end
  end

  assign o_value = r_value;
  assign o_zero  = (r_value == '0);

endmodule

// File: rtl/tff_pulse_sequencer.sv
// Issues N one-cycle toggle pulses on t, spaced by GAP idle cycles, then strobes done.
module tff_pulse_sequencer
  import tff_seq_pkg::*;
#(
  parameter int NT  = NT_DEF,
  parameter int CW  = CW_DEF,
  parameter int GAP = GAP_DEF
) (
  input logic                  i_clk,
  input logic                  i_rst,
  tff_pulse_sequencer_if.slave bus
);

  localparam int GW = gap_cnt_width(GAP);

  state_t        r_state;
  state_t        w_state_next;
  logic [NT-1:0] r_mask;

  logic          w_accept;
  logic [CW-1:0] w_pl_value;
  logic          w_pl_zero;
  logic          w_pl_last;
  logic [GW-1:0] w_gap_value;
  logic          w_gap_zero;
  logic          w_gap_last;
  logic          w_gap_load;

  assign w_accept   = (r_state == ST_IDLE) && bus.cmd_valid;
  assign w_pl_last  = w_pl_zero || (w_pl_value == CW'(1));
  assign w_gap_last = w_gap_zero || (w_gap_value == GW'(1));
  assign w_gap_load = (w_state_next == ST_GAP) && (r_state != ST_GAP);

  tff_seq_cnt #(.W(CW)) u_pulse_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_accept && (bus.cmd_count != '0)),
    .i_load_val (bus.cmd_count),
    .i_dec      (r_state == ST_PULSE),
    .o_value    (w_pl_value),
    .o_zero     (w_pl_zero)
  );

  tff_seq_cnt #(.W(GW)) u_gap_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_gap_load),
    .i_load_val (GW'(GAP)),
    .i_dec      (r_state == ST_GAP),
    .o_value    (w_gap_value),
    .o_zero     (w_gap_zero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_mask <= bus.cmd_mask;
      end
    end
  end

  // A pulse on t during an abort cycle still counts; abort only cuts the remainder.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_state_next = (bus.cmd_count == '0) ? ST_DONE : ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (bus.abort || w_pl_last) begin
          w_state_next = ST_DONE;
        end else if (GAP == 0) begin
          w_state_next = ST_PULSE;
        end else begin
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (bus.abort) begin
          w_state_next = ST_DONE;
        end else if (w_gap_last) begin
          w_state_next = ST_PULSE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.t           = (r_state == ST_PULSE) ? r_mask : '0;
  assign bus.busy        = (r_state == ST_PULSE) || (r_state == ST_GAP);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.cmd_ready   = (r_state == ST_IDLE);
  assign bus.pulses_left = w_pl_value;

endmodule

// File: tb/tb_tff_pulse_sequencer.sv
// Directed bench: one sequencer with GAP=1, one with GAP=0, checked cycle by cycle.
module tb_tff_pulse_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  tff_pulse_sequencer_if #(.NT(3), .CW(8)) bus1 ();
  tff_pulse_sequencer_if #(.NT(3), .CW(8)) bus0 ();

  tff_pulse_sequencer #(.NT(3), .CW(8), .GAP(1)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  tff_pulse_sequencer #(.NT(3), .CW(8), .GAP(0)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic st1(input string tag, input logic [2:0] et, input logic eb, input logic ed,
                     input logic er, input logic [7:0] ep);
    chk({tag, ".t"},     32'(bus1.t),           32'(et));
    chk({tag, ".busy"},  32'(bus1.busy),        32'(eb));
    chk({tag, ".done"},  32'(bus1.done),        32'(ed));
    chk({tag, ".ready"}, 32'(bus1.cmd_ready),   32'(er));
    chk({tag, ".left"},  32'(bus1.pulses_left), 32'(ep));
    $display("g1 %s t=%b busy=%b done=%b ready=%b left=%0d", tag, bus1.t, bus1.busy,
             bus1.done, bus1.cmd_ready, bus1.pulses_left);
  endtask

  task automatic st0(input string tag, input logic [2:0] et, input logic eb, input logic ed,
                     input logic er, input logic [7:0] ep);
    chk({tag, ".t"},     32'(bus0.t),           32'(et));
    chk({tag, ".busy"},  32'(bus0.busy),        32'(eb));
    chk({tag, ".done"},  32'(bus0.done),        32'(ed));
    chk({tag, ".ready"}, 32'(bus0.cmd_ready),   32'(er));
    chk({tag, ".left"},  32'(bus0.pulses_left), 32'(ep));
    $display("g0 %s t=%b busy=%b done=%b ready=%b left=%0d", tag, bus0.t, bus0.busy,
             bus0.done, bus0.cmd_ready, bus0.pulses_left);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    bus1.cmd_valid = 1'b0; bus1.cmd_mask = '0; bus1.cmd_count = '0; bus1.abort = 1'b0;
    bus0.cmd_valid = 1'b0; bus0.cmd_mask = '0; bus0.cmd_count = '0; bus0.abort = 1'b0;

    // Reset state
    repeat (2) cyc();
    st1("rst1", 3'b000, 0, 0, 1, 0);
    st0("rst0", 3'b000, 0, 0, 1, 0);
    rst = 1'b0;
    cyc();

    // GAP=1, mask 101, count 3: pulses in cycles 1,3,5, done in 6
    bus1.cmd_mask = 3'b101; bus1.cmd_count = 8'd3; bus1.cmd_valid = 1'b1;
    cyc(); bus1.cmd_valid = 1'b0;
    st1("a.c1", 3'b101, 1, 0, 0, 3);
    cyc(); st1("a.c2", 3'b000, 1, 0, 0, 2);
    cyc(); st1("a.c3", 3'b101, 1, 0, 0, 2);
    cyc(); st1("a.c4", 3'b000, 1, 0, 0, 1);
    cyc(); st1("a.c5", 3'b101, 1, 0, 0, 1);
    cyc(); st1("a.c6", 3'b000, 0, 1, 0, 0);
    cyc(); st1("a.c7", 3'b000, 0, 0, 1, 0);

    // GAP=0, mask 111, count 4: contiguous pulses, done in 5
    bus0.cmd_mask = 3'b111; bus0.cmd_count = 8'd4; bus0.cmd_valid = 1'b1;
    cyc(); bus0.cmd_valid = 1'b0;
    st0("b.c1", 3'b111, 1, 0, 0, 4);
    cyc(); st0("b.c2", 3'b111, 1, 0, 0, 3);
    cyc(); st0("b.c3", 3'b111, 1, 0, 0, 2);
    cyc(); st0("b.c4", 3'b111, 1, 0, 0, 1);
    cyc(); st0("b.c5", 3'b000, 0, 1, 0, 0);
    cyc(); st0("b.c6", 3'b000, 0, 0, 1, 0);

    // count 0: done in cycle 1, ready back in cycle 2
    bus1.cmd_mask = 3'b111; bus1.cmd_count = 8'd0; bus1.cmd_valid = 1'b1;
    cyc(); bus1.cmd_valid = 1'b0;
    st1("c.c1", 3'b000, 0, 1, 0, 0);
    cyc(); st1("c.c2", 3'b000, 0, 0, 1, 0);

    // count 5, abort during the 2nd pulse, then a normal follow-up command
    bus1.cmd_mask = 3'b011; bus1.cmd_count = 8'd5; bus1.cmd_valid = 1'b1;
    cyc(); bus1.cmd_valid = 1'b0;
    st1("d.c1", 3'b011, 1, 0, 0, 5);
    cyc(); st1("d.c2", 3'b000, 1, 0, 0, 4);
    cyc(); st1("d.c3", 3'b011, 1, 0, 0, 4);
    bus1.abort = 1'b1;
    cyc(); st1("d.c4", 3'b000, 0, 1, 0, 3);
    bus1.abort = 1'b0;
    cyc(); st1("d.c5", 3'b000, 0, 0, 1, 3);
    bus1.cmd_mask = 3'b001; bus1.cmd_count = 8'd1; bus1.cmd_valid = 1'b1;
    cyc(); bus1.cmd_valid = 1'b0;
    st1("d.n1", 3'b001, 1, 0, 0, 1);
    cyc(); st1("d.n2", 3'b000, 0, 1, 0, 0);
    cyc(); st1("d.n3", 3'b000, 0, 0, 1, 0);

    // Reset asserted mid-gap acts immediately and kills the run silently
    bus1.cmd_mask = 3'b110; bus1.cmd_count = 8'd3; bus1.cmd_valid = 1'b1;
    cyc(); bus1.cmd_valid = 1'b0;
    st1("e.c1", 3'b110, 1, 0, 0, 3);
    cyc(); st1("e.c2", 3'b000, 1, 0, 0, 2);
    #2 rst = 1'b1;
    #1 st1("e.async", 3'b000, 0, 0, 1, 0);
    cyc(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(); st1($sformatf("e.post%0d", k), 3'b000, 0, 0, 1, 0);
    end

    // cmd_valid held through a run with changing count/mask
    bus1.cmd_mask = 3'b101; bus1.cmd_count = 8'd2; bus1.cmd_valid = 1'b1;
    cyc(); st1("f.c1", 3'b101, 1, 0, 0, 2);
    bus1.cmd_mask = 3'b010; bus1.cmd_count = 8'd7;
    cyc(); st1("f.c2", 3'b000, 1, 0, 0, 1);
    bus1.cmd_count = 8'd8;
    cyc(); st1("f.c3", 3'b101, 1, 0, 0, 1);
    bus1.cmd_count = 8'd9;
    cyc(); st1("f.c4", 3'b000, 0, 1, 0, 0);
    bus1.cmd_count = 8'd10;
    cyc(); st1("f.c5", 3'b000, 0, 0, 1, 0);
    bus1.cmd_count = 8'd11;
    cyc(); st1("f.c6", 3'b010, 1, 0, 0, 11);
    bus1.cmd_valid = 1'b0; bus1.abort = 1'b1;
    cyc(); st1("f.c7", 3'b000, 0, 1, 0, 10);
    bus1.abort = 1'b0;
    cyc(); st1("f.c8", 3'b000, 0, 0, 1, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
